// File: rtl/mem_arb_pkg.sv
// Shared defaults and state encoding for the CPU/video memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEFAULT       = 8;
    localparam int unsigned DW_DEFAULT       = 8;
    localparam int unsigned MAX_WAIT_DEFAULT = 4;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_CPU = 2'd1,
        ISSUE_VID = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of cycles the video port has been kept waiting.
// Flags starvation once the count reaches MAX_WAIT.
module arb_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic vid_req,
    input  logic vid_gnt,
    output logic starved
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Count refused video cycles; clear on acceptance or when video goes quiet.
    always_comb begin
        cnt_d = cnt_q;
        if (!vid_req || vid_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// CPU normally wins; video wins when it has been starved for MAX_WAIT cycles.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | no access on the RAM port this cycle
// ISSUE_CPU | CPU access presented to RAM this cycle
// ISSUE_VID | video read presented to RAM this cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          vid_rvalid_q, vid_rvalid_d;
    logic          starved;

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clock   (clock),
        .reset   (reset),
        .vid_req (vid_req),
        .vid_gnt (vid_gnt),
        .starved (starved)
    );

    // Grant decision, next state and the RAM command captured at acceptance.
    always_comb begin
        cpu_gnt      = 1'b0;
        vid_gnt      = 1'b0;
        state_d      = IDLE;
        addr_d       = addr_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        // Read data returns the cycle after the issue cycle; writes return nothing.
        cpu_rvalid_d = (state_q == ISSUE_CPU) && !we_q;
        vid_rvalid_d = (state_q == ISSUE_VID);

        // Grants are held off while reset is asserted.
        if (reset) begin
            if (vid_req && (starved || !cpu_req)) begin
                vid_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end

        if (cpu_gnt) begin
            state_d = ISSUE_CPU;
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
        end else if (vid_gnt) begin
            state_d = ISSUE_VID;
            addr_d  = vid_addr;
        end
    end

    // State, RAM command and read-valid pipeline registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rvalid_q <= vid_rvalid_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clock;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       vid_req;
    logic [7:0] vid_addr;
    logic       vid_gnt, vid_rvalid;
    logic [7:0] vid_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .AW       (8),
        .DW       (8),
        .MAX_WAIT (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM: filled with addr ^ 0xB5 while reset is low, so RAM[0x10] = 0xA5.
    logic [7:0] ram [256];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hB5;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 8'h00;
        cpu_wdata = 8'h00;
        vid_req   = 1'b0;
        vid_addr  = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " cpu_gnt"},    32'(cpu_gnt),    32'd0);
        check_eq({tag, " vid_gnt"},    32'(vid_gnt),    32'd0);
        check_eq({tag, " mem_we"},     32'(mem_we),     32'd0);
        check_eq({tag, " mem_addr"},   32'(mem_addr),   32'd0);
        check_eq({tag, " mem_wdata"},  32'(mem_wdata),  32'd0);
        check_eq({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        check_eq({tag, " vid_rvalid"}, 32'(vid_rvalid), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        clear_reqs();

        // Reset state, with requests present to show grants are suppressed.
        #11;
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 8'h33;
        vid_req  = 1'b1;
        #1;
        check_all_zero("reset");
        check_eq("reset state", 32'(dut.state_q), 32'(IDLE));
        clear_reqs();

        // Single CPU read straight out of reset (first edge after release).
        #10;
        reset    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 8'h10;
        #1;
        check_eq("rd cpu_gnt", 32'(cpu_gnt), 32'd1);
        check_eq("rd vid_gnt", 32'(vid_gnt), 32'd0);
        next_cycle();
        clear_reqs();
        check_eq("rd mem_addr", 32'(mem_addr), 32'h10);
        check_eq("rd mem_we", 32'(mem_we), 32'd0);
        check_eq("rd rvalid early", 32'(cpu_rvalid), 32'd0);
        next_cycle();
        check_eq("rd cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check_eq("rd cpu_rdata", 32'(cpu_rdata), 32'hA5);
        check_eq("rd vid_rvalid", 32'(vid_rvalid), 32'd0);
        next_cycle();
        check_eq("rd rvalid pulse", 32'(cpu_rvalid), 32'd0);
        next_cycle();

        // CPU write 0x3C to 0x20, then read back-to-back.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h20;
        cpu_wdata = 8'h3C;
        #1;
        check_eq("wr cpu_gnt", 32'(cpu_gnt), 32'd1);
        next_cycle();
        cpu_we = 1'b0;
        check_eq("wr mem_we", 32'(mem_we), 32'd1);
        check_eq("wr mem_addr", 32'(mem_addr), 32'h20);
        check_eq("wr mem_wdata", 32'(mem_wdata), 32'h3C);
        #1;
        check_eq("wr rd cpu_gnt", 32'(cpu_gnt), 32'd1);
        next_cycle();
        clear_reqs();
        check_eq("wr mem_we one cycle", 32'(mem_we), 32'd0);
        check_eq("wr no rvalid", 32'(cpu_rvalid), 32'd0);
        next_cycle();
        check_eq("wr rd cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check_eq("wr rd cpu_rdata", 32'(cpu_rdata), 32'h3C);
        next_cycle();
        check_eq("wr rd rvalid pulse", 32'(cpu_rvalid), 32'd0);
        next_cycle();

        // Interleaved reads: cpu 0x01,0x03,.. and vid 0x02,0x04,.. one per cycle.
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                check_eq($sformatf("il cpu_rvalid c%0d", c), 32'(cpu_rvalid), 32'((c - 2) % 2 == 0));
                check_eq($sformatf("il vid_rvalid c%0d", c), 32'(vid_rvalid), 32'((c - 2) % 2 == 1));
                check_eq($sformatf("il rdata c%0d", c), 32'(mem_rdata), 32'(8'(c - 1) ^ 8'hB5));
                if ((c - 2) % 2 == 0)
                    check_eq($sformatf("il cpu_rdata c%0d", c), 32'(cpu_rdata), 32'(8'(c - 1) ^ 8'hB5));
                else
                    check_eq($sformatf("il vid_rdata c%0d", c), 32'(vid_rdata), 32'(8'(c - 1) ^ 8'hB5));
            end else begin
                check_eq($sformatf("il idle rvalid c%0d", c), 32'(cpu_rvalid | vid_rvalid), 32'd0);
            end
            clear_reqs();
            if (c < 8) begin
                if (c % 2 == 0) begin
                    cpu_req  = 1'b1;
                    cpu_addr = 8'(c + 1);
                end else begin
                    vid_req  = 1'b1;
                    vid_addr = 8'(c + 1);
                end
            end
            #1;
            check_eq($sformatf("il cpu_gnt c%0d", c), 32'(cpu_gnt), 32'(c < 8 && c % 2 == 0));
            check_eq($sformatf("il vid_gnt c%0d", c), 32'(vid_gnt), 32'(c < 8 && c % 2 == 1));
            check_eq($sformatf("il overlap c%0d", c), 32'(cpu_gnt & vid_gnt), 32'd0);
            next_cycle();
        end
        check_eq("il tail rvalid", 32'(cpu_rvalid | vid_rvalid), 32'd0);

        // Starvation: both held; video wins on the 5th and 10th cycles.
        for (int c = 0; c < 10; c++) begin
            cpu_req  = 1'b1;
            cpu_addr = 8'h40;
            vid_req  = 1'b1;
            vid_addr = 8'h41;
            #1;
            check_eq($sformatf("starve vid_gnt c%0d", c), 32'(vid_gnt), 32'(c == 4 || c == 9));
            check_eq($sformatf("starve cpu_gnt c%0d", c), 32'(cpu_gnt), 32'(!(c == 4 || c == 9)));
            next_cycle();
        end
        clear_reqs();
        repeat (3) next_cycle();

        // Reset asserted in the issue cycle of a video read.
        vid_req  = 1'b1;
        vid_addr = 8'h05;
        #1;
        check_eq("rst vid_gnt", 32'(vid_gnt), 32'd1);
        next_cycle();
        clear_reqs();
        check_eq("rst issue addr", 32'(mem_addr), 32'h05);
        reset = 1'b0;
        #1;
        check_all_zero("rst mid");
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check_eq($sformatf("rst held vid_rvalid c%0d", c), 32'(vid_rvalid), 32'd0);
            check_eq($sformatf("rst held mem_addr c%0d", c), 32'(mem_addr), 32'd0);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check_eq($sformatf("rst post vid_rvalid c%0d", c), 32'(vid_rvalid), 32'd0);
        end

        // Idle for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            check_eq($sformatf("idle state c%0d", c), 32'(dut.state_q), 32'(IDLE));
            check_eq($sformatf("idle activity c%0d", c),
                     32'({mem_we, cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid}), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter AW, default 8, meaning memory address width.
REQ-002 The block SHALL take parameter DW, default 8, meaning memory data width.
REQ-003 The block SHALL take parameter MAX_WAIT, default 4, meaning video starvation limit in cycles (range 1..15).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports cpu_req, input, 1, CPU access request; cpu_we, input, 1, CPU write enable; cpu_addr, input, AW, CPU address; cpu_wdata, input, DW, CPU write data.
REQ-007 The block SHALL have ports cpu_gnt, output, 1, CPU request accepted this cycle; cpu_rvalid, output, 1, CPU read data valid; cpu_rdata, output, DW, CPU read data.
REQ-008 The block SHALL have ports vid_req, input, 1, video read request; vid_addr, input, AW, video address.
REQ-009 The block SHALL have ports vid_gnt, output, 1, video request accepted; vid_rvalid, output, 1, video read data valid; vid_rdata, output, DW, video read data.
REQ-010 The block SHALL have ports mem_addr, output, AW; mem_we, output, 1; mem_wdata, output, DW; mem_rdata, input, DW (single-port synchronous RAM, read data one cycle after address).

Function
REQ-011 Grants SHALL be combinational from current requests and registered state; a request is accepted at the rising edge where req and gnt are both high.
REQ-012 At most one of cpu_gnt, vid_gnt SHALL be high in any cycle.
REQ-013 Priority SHALL be: vid if vid_req and wait_cnt == MAX_WAIT; else cpu if cpu_req; else vid if vid_req.
REQ-014 Requesters SHALL hold req, addr, we, wdata stable until accepted; the arbiter SHALL NOT depend on deassertion before acceptance.
REQ-015 An accepted request SHALL drive mem_addr/mem_we/mem_wdata from registers in the cycle after acceptance (issue cycle); mem_we SHALL be high only for accepted CPU writes.
REQ-016 FSM states SHALL be IDLE (no issue), ISSUE_CPU, ISSUE_VID; next state is the owner of the request accepted at this edge, else IDLE.
REQ-017 For a read issued in cycle N, the matching rvalid SHALL pulse high for exactly cycle N+1 with rdata = mem_rdata; total read latency from acceptance = 2 cycles.
REQ-018 CPU writes SHALL produce no cpu_rvalid.
REQ-019 rdata outputs SHALL be driven to mem_rdata at all times; only rvalid qualifies them.
REQ-020 wait_cnt SHALL increment (saturating at MAX_WAIT) each cycle vid_req is high and vid_gnt low, and clear to 0 when vid is accepted or vid_req is low.
REQ-021 Back-to-back acceptances SHALL be supported: one request per cycle, full throughput.
REQ-022 Simultaneous cpu_req and vid_req with wait_cnt < MAX_WAIT SHALL grant cpu.

Reset
REQ-023 While reset is low: state IDLE, wait_cnt 0, mem_we 0, mem_addr 0, mem_wdata 0, both rvalid 0, both gnt 0.
REQ-024 Reset asserted mid-operation SHALL discard any issued request and pending rvalid; no rvalid SHALL appear after release for pre-reset requests.
REQ-025 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-026 Package mem_arb_pkg SHALL hold AW/DW/MAX_WAIT defaults and the state enumeration (IDLE, ISSUE_CPU, ISSUE_VID).
REQ-027 The saturating starvation counter SHALL be a sub-module named arb_wait_ctr.

Verification
REQ-028 Single CPU read: cpu_req, addr 0x10, RAM[0x10]=0xA5 -> cpu_gnt same cycle, mem_addr=0x10 next cycle, cpu_rvalid with 0xA5 two cycles after acceptance.
REQ-029 CPU write then read: write 0x3C to 0x20, then read 0x20 -> mem_we high one cycle only, read returns 0x3C, no rvalid for the write.
REQ-030 Starvation: cpu_req and vid_req held continuously, MAX_WAIT=4 -> vid granted on 5th cycle, wait_cnt cleared, cpu granted next cycle.
REQ-031 Interleaved reads: alternating cpu/vid addresses 0x01..0x08 -> every rvalid routed to correct owner, no gnt overlap, no lost or duplicated rvalid.
REQ-032 Reset mid-read: assert reset in issue cycle of a vid read -> vid_rvalid never pulses, all outputs 0 until release.
REQ-033 Idle: no requests for 20 cycles -> state IDLE, mem_we 0, no gnt, no rvalid.
